// File: rtl/instr_fetch_unit.sv
// Instruction-fetch initiator: issues word fetches under a prefetch credit limit,
// buffers in-order responses with their PCs and flushes on taken redirects.
module instr_fetch_unit #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
   parameter int unsigned           FIFO_DEPTH = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic                  instr_req_o,
   output logic [ADDR_WIDTH-1:0] instr_addr_o,
   input  logic                  instr_gnt_i,
   input  logic                  instr_rvalid_i,
   input  logic [DATA_WIDTH-1:0] instr_rdata_i,
   output logic                  instr_valid_o,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] instr_pc_o,
   input  logic                  instr_ready_i,
   input  logic                  branch_tkn_i,
   input  logic [ADDR_WIDTH-1:0] tgt_addr_i
);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]        DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(4);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_REQ_STALE} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   logic [ADDR_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
   logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0]      out_q, out_d;
   logic [CNT_W-1:0]      disc_q, disc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [PTR_W-1:0]      rptr_q, rptr_d;
   logic [PTR_W-1:0]      wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] pc_mem_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] pc_mem_d [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_d [FIFO_DEPTH];

   logic                  hold, pend, pop, push, credit, req, gnt_acc, pend_d;
   logic [CNT_W:0]        used;
   logic [ADDR_WIDTH-1:0] tgt_al;

   // A same-cycle pop frees its slot, which keeps one fetch per cycle at depth 2.
   always_comb begin
      hold    = (state_q != S_IDLE);
      pend    = (state_q == S_REQ_STALE);
      pop     = (cnt_q != '0) && instr_ready_i;
      used    = {1'b0, out_q} + {1'b0, cnt_q} - (CNT_W + 1)'(pop);
      credit  = (used < DEPTH_C);
      req     = ~rst_i & (hold | credit);
      gnt_acc = req & instr_gnt_i;
      push    = instr_rvalid_i & (disc_q == '0) & ~branch_tkn_i;
      tgt_al  = tgt_addr_i & ~ADDR_WIDTH'(3);
   end

   always_comb begin
      req_addr_d = req_addr_q;
      pend_tgt_d = pend_tgt_q;
      pend_d     = pend;
      if (gnt_acc) begin
         req_addr_d = pend ? pend_tgt_q : req_addr_q + STEP;
         pend_d     = 1'b0;
      end
      if (branch_tkn_i) begin
         if (req && !instr_gnt_i) begin
            pend_d     = 1'b1;
            pend_tgt_d = tgt_al;
         end else begin
            req_addr_d = tgt_al;
         end
      end
      if (req && !instr_gnt_i) state_d = pend_d ? S_REQ_STALE : S_REQ;
      else                     state_d = S_IDLE;
   end

   // A stale request granted after its redirect is owed one extra discard.
   always_comb begin
      out_d  = out_q + CNT_W'(gnt_acc) - CNT_W'(instr_rvalid_i);
      disc_d = disc_q;
      if (instr_rvalid_i && (disc_q != '0)) disc_d = disc_d - CNT_W'(1);
      if (gnt_acc && pend)                  disc_d = disc_d + CNT_W'(1);
      if (branch_tkn_i)                     disc_d = out_d;
   end

   always_comb begin
      cnt_d      = cnt_q;
      rptr_d     = rptr_q;
      wptr_d     = wptr_q;
      rsp_pc_d   = rsp_pc_q;
      pc_mem_d   = pc_mem_q;
      data_mem_d = data_mem_q;
      if (branch_tkn_i) begin
         cnt_d    = '0;
         rptr_d   = '0;
         wptr_d   = '0;
         rsp_pc_d = tgt_al;
      end else begin
         if (push) begin
            pc_mem_d[wptr_q]   = rsp_pc_q;
            data_mem_d[wptr_q] = instr_rdata_i;
            wptr_d             = wptr_q + PTR_W'(1);
            rsp_pc_d           = rsp_pc_q + STEP;
         end
         if (pop) rptr_d = rptr_q + PTR_W'(1);
         cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         req_addr_q <= BOOT_ADDR;
         pend_tgt_q <= '0;
         rsp_pc_q   <= BOOT_ADDR;
         out_q      <= '0;
         disc_q     <= '0;
         cnt_q      <= '0;
         rptr_q     <= '0;
         wptr_q     <= '0;
         pc_mem_q   <= '{default: '0};
         data_mem_q <= '{default: '0};
      end else begin
         state_q    <= state_d;
         req_addr_q <= req_addr_d;
         pend_tgt_q <= pend_tgt_d;
         rsp_pc_q   <= rsp_pc_d;
         out_q      <= out_d;
         disc_q     <= disc_d;
         cnt_q      <= cnt_d;
         rptr_q     <= rptr_d;
         wptr_q     <= wptr_d;
         pc_mem_q   <= pc_mem_d;
         data_mem_q <= data_mem_d;
      end
   end

   always_comb begin
      instr_req_o   = req;
      instr_addr_o  = req_addr_q;
      instr_valid_o = (cnt_q != '0);
      instr_o       = instr_valid_o ? data_mem_q[rptr_q] : '0;
      instr_pc_o    = instr_valid_o ? pc_mem_q[rptr_q] : '0;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory model with epoch-tagged grants feeds a
// scoreboard of expected {pc, instr} entries checked at each decoder pop.
module tb_instr_fetch_unit;
   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] BOOT  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        instr_req_o, instr_gnt_i, instr_rvalid_i, instr_valid_o;
   logic        instr_ready_i, branch_tkn_i;
   logic [31:0] instr_addr_o, instr_rdata_i, instr_o, instr_pc_o, tgt_addr_i;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .BOOT_ADDR (BOOT),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .instr_req_o   (instr_req_o),
      .instr_addr_o  (instr_addr_o),
      .instr_gnt_i   (instr_gnt_i),
      .instr_rvalid_i(instr_rvalid_i),
      .instr_rdata_i (instr_rdata_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_ready_i (instr_ready_i),
      .branch_tkn_i  (branch_tkn_i),
      .tgt_addr_i    (tgt_addr_i)
   );

   typedef struct {
      logic [31:0] a_dut;
      logic [31:0] a_exp;
      int          epoch;
      bit          stale;
      int          due;
   } rsp_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   rsp_t        rsp_q[$];
   exp_t        exp_q[$];
   logic [31:0] grant_log[$];

   int          n_chk = 0, n_pass = 0;
   bit          gnt_en = 1'b1, rdy_en = 1'b1, br_req = 1'b0;
   int          lat = 1;
   logic [31:0] br_tgt = '0;
   int          cyc = 0, epoch = 0, first_vld = -1, pop_cnt = 0, grant_cnt = 0;
   bit          stale = 1'b0, hold_prev = 1'b0, br_prev = 1'b0;
   logic [31:0] stale_tgt = '0, m_next = BOOT, hold_addr = '0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
   endtask

   function automatic logic [31:0] fdata(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_96E1;
   endfunction

   task automatic wait_valid(output int k);
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!instr_valid_o && k < 30);
      check("wait_valid_bound", instr_valid_o, 1'b1);
   endtask

   // Memory, decoder and scoreboard: drive at the falling edge, observe 1 ns later.
   initial begin
      rsp_t        r;
      exp_t        e;
      logic        gnt;
      logic [31:0] br_al;
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
      instr_ready_i  = 1'b0;
      branch_tkn_i   = 1'b0;
      tgt_addr_i     = '0;
      forever begin
         @(negedge clk);
         instr_ready_i = rdy_en;
         branch_tkn_i  = br_req;
         tgt_addr_i    = br_tgt;
         br_req        = 1'b0;
         #1;
         if (rst_i) begin
            check("rst_req", instr_req_o, 1'b0);
            check("rst_addr", instr_addr_o, BOOT);
            check("rst_valid", instr_valid_o, 1'b0);
            check("rst_head", {instr_pc_o, instr_o}, 64'h0);
            instr_gnt_i    = 1'b0;
            instr_rvalid_i = 1'b0;
            branch_tkn_i   = 1'b0;
            rsp_q.delete();
            exp_q.delete();
            grant_log.delete();
            cyc = 0; epoch = 0; first_vld = -1; pop_cnt = 0; grant_cnt = 0;
            stale = 1'b0; hold_prev = 1'b0; br_prev = 1'b0; m_next = BOOT;
         end else begin
            br_al = {tgt_addr_i[31:2], 2'b00};
            if (hold_prev) begin
               check("hold_req", instr_req_o, 1'b1);
               check("hold_addr", instr_addr_o, hold_addr);
            end
            if (br_prev) check("redir_flush_valid", instr_valid_o, 1'b0);
            check("credit_cap", (rsp_q.size() + exp_q.size()) <= DEPTH, 1'b1);
            if (instr_valid_o) begin
               if (first_vld < 0) first_vld = cyc;
               if (instr_ready_i) begin
                  pop_cnt++;
                  check("sb_nonempty", exp_q.size() > 0, 1'b1);
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     check("pop_pc", instr_pc_o, e.pc);
                     check("pop_instr", instr_o, e.data);
                  end
               end
            end else begin
               check("idle_head", {instr_pc_o, instr_o}, 64'h0);
            end
            gnt = instr_req_o && gnt_en;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
               r = rsp_q.pop_front();
               instr_rvalid_i = 1'b1;
               instr_rdata_i  = fdata(r.a_dut);
               if (!r.stale && r.epoch == epoch && !branch_tkn_i) begin
                  e.pc   = r.a_exp;
                  e.data = fdata(r.a_exp);
                  exp_q.push_back(e);
               end
            end else begin
               instr_rvalid_i = 1'b0;
               instr_rdata_i  = $urandom;
            end
            instr_gnt_i = gnt;
            if (gnt) begin
               check("gnt_addr", instr_addr_o, m_next);
               grant_cnt++;
               grant_log.push_back(instr_addr_o);
               r.a_dut = instr_addr_o;
               r.a_exp = m_next;
               r.epoch = epoch;
               r.stale = stale;
               r.due   = cyc + lat;
               rsp_q.push_back(r);
               if (stale) begin
                  m_next = stale_tgt;
                  stale  = 1'b0;
               end else begin
                  m_next = m_next + 32'd4;
               end
            end
            if (branch_tkn_i) begin
               if (instr_req_o && !gnt) begin
                  stale     = 1'b1;
                  stale_tgt = br_al;
               end else begin
                  m_next = br_al;
               end
               epoch++;
               exp_q.delete();
            end
            hold_prev = instr_req_o && !gnt;
            hold_addr = instr_addr_o;
            br_prev   = branch_tkn_i;
            cyc++;
         end
      end
   end

   initial begin
      int k, g0, idx;
      repeat (2) @(posedge clk);
      #2 rst_i = 1'b0;

      // Streaming from boot: one grant and one delivery per cycle.
      repeat (24) @(posedge clk);
      #1;
      check("first_valid_cycle", first_vld, 2);
      check("stream_pops", pop_cnt, 22);
      check("stream_grants", grant_cnt, 24);

      // Decoder stall fills the FIFO and starves requests.
      rdy_en = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("stall_req_drop", instr_req_o, 1'b0);
      check("stall_valid", instr_valid_o, 1'b1);
      rdy_en = 1'b1;
      repeat (8) @(posedge clk);

      // Grant withheld for three cycles.
      gnt_en = 1'b0;
      g0 = grant_cnt;
      repeat (3) @(posedge clk);
      gnt_en = 1'b1;
      @(posedge clk);
      #1;
      check("gnt_stall_one_grant", grant_cnt - g0, 1);

      // Redirect to an unaligned target with two responses in flight.
      gnt_en = 1'b0;
      repeat (5) @(posedge clk);
      lat = 2;
      gnt_en = 1'b1;
      repeat (2) @(posedge clk);
      check("two_outstanding", rsp_q.size(), 2);
      idx = grant_log.size();
      br_tgt = 32'h0000_0103;
      br_req = 1'b1;
      wait_valid(k);
      check("redir_first_pc", instr_pc_o, 32'h0000_0100);
      check("redir_next_gnt", (grant_log.size() > idx) ? grant_log[idx] : 32'hxxxx_xxxx, 32'h0000_0100);

      // Redirect while a request at 0x8 is raised but not granted.
      rdy_en = 1'b0;
      lat = 1;
      gnt_en = 1'b1;
      @(posedge clk);
      #2 rst_i = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst_i = 1'b0;
      repeat (6) @(posedge clk);
      check("full_req_low", instr_req_o, 1'b0);
      gnt_en = 1'b0;
      rdy_en = 1'b1;
      @(posedge clk);
      idx = grant_log.size();
      br_tgt = 32'h0000_0200;
      br_req = 1'b1;
      repeat (2) @(posedge clk);
      gnt_en = 1'b1;
      wait_valid(k);
      check("stale_gnt_old", (grant_log.size() > idx) ? grant_log[idx] : 32'hxxxx_xxxx, 32'h0000_0008);
      check("stale_gnt_new", (grant_log.size() > idx + 1) ? grant_log[idx+1] : 32'hxxxx_xxxx, 32'h0000_0200);
      check("stale_first_pc", instr_pc_o, 32'h0000_0200);

      // Redirect in a cycle that also pops and receives a response.
      repeat (6) @(posedge clk);
      br_tgt = 32'h0000_0300;
      br_req = 1'b1;
      wait_valid(k);
      check("redir_latency", k, 3);
      check("redir_stream_pc", instr_pc_o, 32'h0000_0300);
      repeat (6) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, want finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch initiator for the toothless core. Drives request/grant/response transactions toward the instruction memory, which responds to them. Buffers returned words with their PCs in a small prefetch FIFO and presents them to the decoder via a valid/ready handshake. Handles taken-branch/jump redirects by flushing buffered and in-flight fetches.

## Interface
- ADDR_WIDTH, 32, instruction address width
- DATA_WIDTH, 32, instruction word width
- BOOT_ADDR, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- FIFO_DEPTH, 2, prefetch entries (power of two, ≥2); also the cap on outstanding requests plus buffered entries

Ports:
- clk_i  in  1  clock, all state updates on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- instr_req_o  out  1  fetch request to memory
- instr_addr_o  out  ADDR_WIDTH  word-aligned fetch address
- instr_gnt_i  in  1  memory accepts the request this cycle
- instr_rvalid_i  in  1  response data valid this cycle (in order, one per grant)
- instr_rdata_i  in  DATA_WIDTH  response instruction word
- instr_valid_o  out  1  FIFO head valid toward decoder
- instr_o  out  DATA_WIDTH  FIFO head instruction
- instr_pc_o  out  ADDR_WIDTH  PC of instr_o
- instr_ready_i  in  1  decoder consumes head when instr_valid_o=1
- branch_tkn_i  in  1  redirect strobe, one cycle
- tgt_addr_i  in  ADDR_WIDTH  redirect target; bits [1:0] ignored, forced to 0

## Operation
- Registers:
  - req_addr: next address to request.
  - outstanding: count of granted requests without a response, 0..FIFO_DEPTH.
  - discard: count of responses to drop, ≤ outstanding.
  - rsp_pc: PC of the next kept response.
  - FIFO entries of {pc, instr}.
  - hold: request raised and not yet granted.
  - pend_redir, pend_tgt.
- Credit: a new request may be raised when outstanding + fifo_count < FIFO_DEPTH.
- Request rule: instr_req_o = hold OR credit. Once raised, req and addr stay stable until the gnt cycle (hold=1).
- On gnt (req high):
  - outstanding++.
  - req_addr += 4 (modulo 2^ADDR_WIDTH; wrap from 0xFFFF_FFFC to 0 is legal).
- On rvalid:
  - outstanding--.
  - If discard>0: discard--, data dropped.
  - Else: push {rsp_pc, rdata} and rsp_pc += 4.
  - Credit guarantees no push to a full FIFO.
- Pop: instr_valid_o && instr_ready_i removes the head.
- Outputs: instr_valid_o = FIFO non-empty. instr_o and instr_pc_o are the head when valid and 0 otherwise.
- Redirect (branch_tkn_i=1):
  - A pop in the same cycle completes. All remaining entries and any push in this cycle are flushed.
  - discard = outstanding after this cycle's gnt/rvalid updates. A same-cycle gnt is counted; a same-cycle rvalid is dropped.
  - rsp_pc = aligned tgt.
  - If req is high and gnt low this cycle: pend_redir=1, pend_tgt=tgt. The held request completes at its old address and is discarded. On its gnt, req_addr = pend_tgt and pend_redir clears.
  - Otherwise: req_addr = aligned tgt directly.
  - A new redirect while pend_redir=1 overwrites pend_tgt.
- States (encoded by hold/pend_redir):
  - IDLE: no req, credit exhausted.
  - REQ: req high.
  - REQ_STALE: req high with pend_redir.
  - Transitions follow the credit, gnt and redirect rules above.
- Memory errors are not supported.

## Timing
- Reset values (held while rst_i=1):
  - instr_req_o=0, instr_addr_o=BOOT_ADDR, instr_valid_o=0, instr_o=0, instr_pc_o=0.
  - FIFO empty; outstanding=0, discard=0, rsp_pc=BOOT_ADDR, hold=0, pend_redir=0.
- Reset may assert mid-transaction. Late rvalids after reset are a memory-side violation and need not be handled.
- First cycle with rst_i=0: instr_req_o=1, addr=BOOT_ADDR.
- Latency: a response in cycle N gives instr_valid_o in cycle N+1 (registered FIFO, no bypass).
- With gnt in cycle 0 and rvalid in cycle 1, the instruction is visible in cycle 2.
- Throughput: with FIFO_DEPTH=2, single-cycle gnt and next-cycle rvalid, and ready held at 1, one instruction per cycle is sustained.
- Redirect at edge N:
  - instr_valid_o=0 in cycle N+1, unless data arrives from the new stream.
  - The first new-target request is raised in cycle N+1, or in the cycle after the stale gnt.
  - The earliest new-target instruction is visible at N+3.

## Test plan
- Reset release, memory gnt=1 always, rvalid one cycle after gnt, ready=1 -> addrs 0x0, 0x4, 0x8… on consecutive cycles; instr_pc_o 0x0 at cycle 2, then +4 each cycle.
- ready=0 for 10 cycles -> FIFO fills to 2 and instr_req_o drops. After ready=1, the order is preserved and the count stays ≤2.
- gnt withheld 3 cycles -> instr_req_o and instr_addr_o are stable throughout; exactly one grant is counted.
- Redirect to 0x0000_0103 while 2 requests are outstanding -> both responses dropped; next request addr 0x100; first delivered instr_pc_o=0x100.
- Redirect while req is high and ungranted at 0x8, gnt 2 cycles later -> 0x8 is requested, then 0x200 (tgt). The 0x8 data is never presented.
- Redirect in the same cycle as pop and rvalid -> the popped word is delivered; the rvalid word is dropped; FIFO is empty the next cycle.
